// File: rtl/icmp_echo_filter_pkg.sv
// Shared types and IPv4/ICMP header constants for the echo path.
// The echo responder imports the same header offsets and values.
package icmp_pkg;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  empty;
    logic        sop;
    logic        eop;
  } beat_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DRAIN,
    S_SEND
  } state_t;

  localparam int unsigned HDR_W_VER   = 0;
  localparam int unsigned HDR_W_PROTO = 2;
  localparam int unsigned HDR_W_TYPE  = 5;
  localparam int unsigned MIN_WORDS   = 6;

  localparam logic [7:0] IP_VER_IHL    = 8'h45;
  localparam logic [7:0] IP_PROTO_ICMP = 8'h01;
  localparam logic [7:0] ICMP_ECHO_REQ = 8'h08;

  // bit0: version/IHL ok, bit1: protocol ok, bit2: echo type ok
  function automatic logic [2:0] hdr_update(
    input logic [2:0]  ok,
    input int unsigned idx,
    input logic [15:0] d
  );
    logic [2:0] r;
    r = ok;
    if (idx == HDR_W_VER)
      r = {2'b00, d[7:0] == IP_VER_IHL};
    if (idx == HDR_W_PROTO)
      r[1] = (d[15:8] == IP_PROTO_ICMP);
    if (idx == HDR_W_TYPE)
      r[2] = (d[7:0] == ICMP_ECHO_REQ);
    return r;
  endfunction

endpackage

// File: rtl/icmp_echo_filter_if.sv
// Avalon-ST beat bundle with valid/ready handshake.
interface icmp_echo_filter_if;
  import icmp_pkg::*;

  beat_t beat;
  logic  valid;
  logic  ready;

  modport master (
    output beat,
    output valid,
    input  ready
  );

  modport slave (
    input  beat,
    input  valid,
    output ready
  );

endinterface

// File: rtl/icmp_echo_filter_pkt_buffer.sv
// Simple dual-port packet store with registered, enabled read.
module icmp_pkt_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  // Read data holds while i_re is low, so a stalled egress word stays put.
  always_ff @(posedge clk) begin
    if (i_re)
      o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/icmp_echo_filter.sv
// Store-and-forward ingress filter: passes only ICMP Echo Requests.
module icmp_echo_filter
  import icmp_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      stream_in_data,
  input  logic [1:0]       stream_in_empty,
  input  logic             stream_in_valid,
  input  logic             stream_in_startofpacket,
  input  logic             stream_in_endofpacket,
  output logic             stream_in_ready,
  output logic [31:0]      stream_out_data,
  output logic [1:0]       stream_out_empty,
  output logic             stream_out_valid,
  output logic             stream_out_startofpacket,
  output logic             stream_out_endofpacket,
  input  logic             stream_out_ready,
  output logic [CNT_W-1:0] stat_passed,
  output logic [CNT_W-1:0] stat_dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] ONE  = PW'(1);
  localparam logic [PW-1:0] FULL = PW'(DEPTH);
  localparam logic [PW-1:0] MINW = PW'(MIN_WORDS);

  state_t          r_state, w_state_n;
  logic [PW-1:0]   r_rx_ptr, w_rx_n;
  logic [PW-1:0]   r_tx_ptr, w_tx_n;
  logic [PW-1:0]   r_len, w_len_n;
  logic [1:0]      r_empty, w_empty_n;
  logic [2:0]      r_ok, w_ok_n;
  logic            r_out_valid, w_ov_n;
  logic            r_out_sop, w_os_n;
  logic            r_out_eop, w_oe_n;
  logic [1:0]      r_out_empty, w_oem_n;
  logic [CNT_W-1:0] r_passed, w_pass_n;
  logic [CNT_W-1:0] r_dropped, w_drop_n;

  beat_t         w_in;
  logic          w_in_ready, w_acc;
  logic [PW-1:0] w_rx_nxt, w_tx_nxt;
  logic [2:0]    w_ok_cur, w_ok0;
  logic          w_we, w_re;
  logic [AW-1:0] w_waddr, w_raddr;
  logic [31:0]   w_rdata;

  assign w_in = '{
    data:  stream_in_data,
    empty: stream_in_empty,
    sop:   stream_in_startofpacket,
    eop:   stream_in_endofpacket
  };

  assign w_in_ready      = (r_state != S_SEND);
  assign stream_in_ready = w_in_ready;
  assign w_acc    = stream_in_valid && w_in_ready;
  assign w_rx_nxt = r_rx_ptr + ONE;
  assign w_tx_nxt = r_tx_ptr + ONE;
  assign w_ok_cur = hdr_update(r_ok, 32'(r_rx_ptr), w_in.data[15:0]);
  assign w_ok0    = hdr_update(r_ok, 0, w_in.data[15:0]);

  always_comb begin
    w_state_n = r_state;
    w_rx_n    = r_rx_ptr;
    w_tx_n    = r_tx_ptr;
    w_len_n   = r_len;
    w_empty_n = r_empty;
    w_ok_n    = r_ok;
    w_ov_n    = r_out_valid;
    w_os_n    = r_out_sop;
    w_oe_n    = r_out_eop;
    w_oem_n   = r_out_empty;
    w_pass_n  = r_passed;
    w_drop_n  = r_dropped;
    w_we      = 1'b0;
    w_waddr   = AW'(r_rx_ptr);
    w_re      = 1'b0;
    w_raddr   = AW'(w_tx_nxt);
    unique case (r_state)
      S_IDLE, S_DRAIN: begin
        if (w_acc && w_in.sop) begin
          w_we    = 1'b1;
          w_waddr = '0;
          w_ok_n  = w_ok0;
          w_rx_n  = ONE;
          if (w_in.eop) begin
            w_state_n = S_IDLE;
            w_drop_n  = r_dropped + 1'b1;
          end else begin
            w_state_n = S_RECV;
          end
        end else if (w_acc && w_in.eop) begin
          w_state_n = S_IDLE;
        end
      end
      S_RECV: begin
        if (w_acc && w_in.sop) begin
          w_we      = 1'b1;
          w_waddr   = '0;
          w_ok_n    = w_ok0;
          w_rx_n    = ONE;
          w_drop_n  = r_dropped + 1'b1;
          w_state_n = w_in.eop ? S_IDLE : S_RECV;
        end else if (w_acc && r_rx_ptr == FULL) begin
          // No room for this beat: the packet is oversized.
          w_drop_n  = r_dropped + 1'b1;
          w_state_n = w_in.eop ? S_IDLE : S_DRAIN;
        end else if (w_acc) begin
          w_we   = 1'b1;
          w_rx_n = w_rx_nxt;
          w_ok_n = w_ok_cur;
          if (w_in.eop) begin
            w_len_n   = w_rx_nxt;
            w_empty_n = w_in.empty;
            if (w_rx_nxt >= MINW && &w_ok_cur) begin
              w_state_n = S_SEND;
              w_pass_n  = r_passed + 1'b1;
              w_re      = 1'b1;
              w_raddr   = '0;
              w_tx_n    = '0;
              w_ov_n    = 1'b1;
              w_os_n    = 1'b1;
              w_oe_n    = 1'b0;
              w_oem_n   = 2'b00;
            end else begin
              w_state_n = S_IDLE;
              w_drop_n  = r_dropped + 1'b1;
            end
          end
        end
      end
      S_SEND: begin
        if (r_out_valid && stream_out_ready) begin
          if (w_tx_nxt == r_len) begin
            w_ov_n    = 1'b0;
            w_os_n    = 1'b0;
            w_oe_n    = 1'b0;
            w_oem_n   = 2'b00;
            w_state_n = S_IDLE;
          end else begin
            w_re    = 1'b1;
            w_tx_n  = w_tx_nxt;
            w_os_n  = 1'b0;
            w_oe_n  = (w_tx_nxt + ONE == r_len);
            w_oem_n = w_oe_n ? r_empty : 2'b00;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rx_ptr    <= '0;
      r_tx_ptr    <= '0;
      r_len       <= '0;
      r_empty     <= '0;
      r_ok        <= '0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_empty <= '0;
      r_passed    <= '0;
      r_dropped   <= '0;
    end else begin
      r_state     <= w_state_n;
      r_rx_ptr    <= w_rx_n;
      r_tx_ptr    <= w_tx_n;
      r_len       <= w_len_n;
      r_empty     <= w_empty_n;
      r_ok        <= w_ok_n;
      r_out_valid <= w_ov_n;
      r_out_sop   <= w_os_n;
      r_out_eop   <= w_oe_n;
      r_out_empty <= w_oem_n;
      r_passed    <= w_pass_n;
      r_dropped   <= w_drop_n;
    end
  end

  icmp_pkt_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_in.data),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign stream_out_data  = r_out_valid ? w_rdata : '0;
  assign stream_out_empty = r_out_empty;
  assign stream_out_valid = r_out_valid;
  assign stream_out_startofpacket = r_out_sop;
  assign stream_out_endofpacket   = r_out_eop;
  assign stat_passed  = r_passed;
  assign stat_dropped = r_dropped;

endmodule

// File: tb/tb_icmp_echo_filter.sv
// Directed bench for icmp_echo_filter: packet table plus corner sequences.
module tb_icmp_echo_filter;
  import icmp_pkg::*;

  logic clk;
  logic rst;
  logic [15:0] passed, dropped;

  icmp_echo_filter_if in_if ();
  icmp_echo_filter_if out_if ();

  icmp_echo_filter dut (
    .clk                      (clk),
    .reset                    (rst),
    .stream_in_data           (in_if.beat.data),
    .stream_in_empty          (in_if.beat.empty),
    .stream_in_valid          (in_if.valid),
    .stream_in_startofpacket  (in_if.beat.sop),
    .stream_in_endofpacket    (in_if.beat.eop),
    .stream_in_ready          (in_if.ready),
    .stream_out_data          (out_if.beat.data),
    .stream_out_empty         (out_if.beat.empty),
    .stream_out_valid         (out_if.valid),
    .stream_out_startofpacket (out_if.beat.sop),
    .stream_out_endofpacket   (out_if.beat.eop),
    .stream_out_ready         (out_if.ready),
    .stat_passed              (passed),
    .stat_dropped             (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int eop_cyc = 0;
  bit stall_mode = 0;
  logic [31:0] pw [0:127];

  // egress monitor: captures accepted words, watches stalls
  beat_t rx_q[$];
  logic  pv = 1'b0;
  logic  pr = 1'b0;
  beat_t pb;
  int    last_rise = -1;
  int    hold_bad = 0;
  int    hold_seen = 0;
  int    rdy_bad = 0;

  always @(negedge clk) begin
    if (rst) begin
      pv <= 1'b0;
    end else begin
      if (pv && !pr) begin
        hold_seen <= hold_seen + 1;
        if (!out_if.valid || out_if.beat != pb)
          hold_bad <= hold_bad + 1;
      end
      if (out_if.valid && in_if.ready)
        rdy_bad <= rdy_bad + 1;
      if (out_if.valid && !pv)
        last_rise <= cyc;
      if (out_if.valid && out_if.ready)
        rx_q.push_back(out_if.beat);
      pv <= out_if.valid;
      pr <= out_if.ready;
      pb <= out_if.beat;
    end
  end

  // egress ready: steady 1, or the repeating 1,0,0,1 pattern
  initial begin
    int k;
    k = 0;
    out_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode) begin
        out_if.ready = (k % 4 == 0) || (k % 4 == 3);
        k++;
      end else begin
        out_if.ready = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void build(input int n, input logic [7:0] b0,
                                input logic [7:0] proto,
                                input logic [7:0] typ);
    for (int i = 0; i < n && i < 128; i++)
      pw[i] = {8'hA5, 8'(i), 8'(i * 3), 8'(i + 7)};
    pw[0] = {24'h005400, b0};
    pw[2] = {16'h1234, proto, 8'h40};
    pw[5] = {24'h00BEEF, typ};
  endfunction

  // called at posedge+1; returns at posedge+1 of the accepting edge
  task automatic drive_beat(input logic [31:0] d, input logic sop,
                            input logic eop, input logic [1:0] emp);
    int b;
    in_if.valid = 1'b1;
    in_if.beat  = '{data: d, empty: emp, sop: sop, eop: eop};
    b = 0;
    @(negedge clk);
    while (!in_if.ready && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (b >= 500) chk("in_ready_timeout", 64'(b), 64'(0));
    @(posedge clk);
    #1;
    if (eop) eop_cyc = cyc;
  endtask

  task automatic send_pkt(input int n, input logic [1:0] emp,
                          input bit with_eop);
    for (int i = 0; i < n; i++) begin
      drive_beat(pw[i], i == 0, with_eop && i == n - 1,
                 (with_eop && i == n - 1) ? emp : 2'b00);
    end
    in_if.valid = 1'b0;
    in_if.beat  = '0;
  endtask

  task automatic expect_pkt(input int base, input int n,
                            input logic [1:0] emp);
    int b;
    beat_t e;
    b = 0;
    while (rx_q.size() < base + n && b < n * 4 + 50) begin
      @(posedge clk);
      b++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("out_words", 64'(rx_q.size() - base), 64'(n));
    for (int i = 0; i < n && base + i < rx_q.size(); i++) begin
      e = '{data: pw[i], empty: (i == n - 1) ? emp : 2'b00,
            sop: i == 0, eop: i == n - 1};
      chk($sformatf("word%0d", i), 64'(rx_q[base + i]), 64'(e));
    end
  endtask

  task automatic expect_none(input int base);
    repeat (6) @(posedge clk);
    #1;
    chk("no_output", 64'(rx_q.size() - base), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         n;
    logic [7:0] b0;
    logic [7:0] proto;
    logic [7:0] typ;
    logic [1:0] emp;
    bit         pass;
    int         exp_p;
    int         exp_d;
  } vec_t;

  vec_t vt [9];
  int   base;
  int   t0;
  int   b;

  initial begin
    vt[0] = '{21, 8'h45, 8'h01, 8'h08, 2'd0, 1'b1, 1, 0};
    vt[1] = '{21, 8'h45, 8'h06, 8'h08, 2'd0, 1'b0, 1, 1};
    vt[2] = '{ 5, 8'h45, 8'h01, 8'h08, 2'd0, 1'b0, 1, 2};
    vt[3] = '{ 6, 8'h45, 8'h01, 8'h08, 2'd2, 1'b1, 2, 2};
    vt[4] = '{21, 8'h46, 8'h01, 8'h08, 2'd0, 1'b0, 2, 3};
    vt[5] = '{21, 8'h45, 8'h01, 8'h00, 2'd0, 1'b0, 2, 4};
    vt[6] = '{64, 8'h45, 8'h01, 8'h08, 2'd1, 1'b1, 3, 4};
    vt[7] = '{65, 8'h45, 8'h01, 8'h08, 2'd0, 1'b0, 3, 5};
    vt[8] = '{ 1, 8'h45, 8'h01, 8'h08, 2'd0, 1'b0, 3, 6};

    rst = 1'b1;
    in_if.valid = 1'b0;
    in_if.beat  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_if.valid), 64'(0));
    chk("rst_sop_eop", 64'({out_if.beat.sop, out_if.beat.eop}), 64'(0));
    chk("rst_data", 64'({out_if.beat.data, out_if.beat.empty}), 64'(0));
    chk("rst_cnt", 64'({passed, dropped}), 64'(0));
    chk("rst_in_ready", 64'(in_if.ready), 64'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 9; v++) begin
      build(vt[v].n, vt[v].b0, vt[v].proto, vt[v].typ);
      base = rx_q.size();
      send_pkt(vt[v].n, vt[v].emp, 1'b1);
      if (vt[v].pass) begin
        expect_pkt(base, vt[v].n, vt[v].emp);
        chk($sformatf("latency_v%0d", v), 64'(last_rise), 64'(eop_cyc));
      end else begin
        expect_none(base);
      end
      chk($sformatf("passed_v%0d", v), 64'(passed), 64'(vt[v].exp_p));
      chk($sformatf("dropped_v%0d", v), 64'(dropped), 64'(vt[v].exp_d));
    end

    // 85-byte ping under egress backpressure
    do_reset();
    stall_mode = 1'b1;
    build(22, 8'h45, 8'h01, 8'h08);
    base = rx_q.size();
    send_pkt(22, 2'd3, 1'b1);
    expect_pkt(base, 22, 2'd3);
    stall_mode = 1'b0;
    chk("stalls_seen", 64'(hold_seen > 0), 64'(1));
    chk("hold_stable", 64'(hold_bad), 64'(0));
    chk("in_ready_in_send", 64'(rdy_bad), 64'(0));
    chk("stall_passed", 64'(passed), 64'(1));

    // oversized packet drained, then a good one back to back
    do_reset();
    build(70, 8'h45, 8'h01, 8'h08);
    t0 = cyc;
    send_pkt(70, 2'd0, 1'b1);
    chk("drain_cycles", 64'(cyc - t0), 64'(70));
    build(21, 8'h45, 8'h01, 8'h08);
    base = rx_q.size();
    send_pkt(21, 2'd0, 1'b1);
    expect_pkt(base, 21, 2'd0);
    chk("ovf_dropped", 64'(dropped), 64'(1));
    chk("ovf_passed", 64'(passed), 64'(1));

    // sop reasserted at word 10
    do_reset();
    build(21, 8'h45, 8'h01, 8'h08);
    base = rx_q.size();
    send_pkt(10, 2'd0, 1'b0);
    send_pkt(21, 2'd0, 1'b1);
    expect_pkt(base, 21, 2'd0);
    chk("resop_dropped", 64'(dropped), 64'(1));
    chk("resop_passed", 64'(passed), 64'(1));

    // reset while word 7 is on the egress
    do_reset();
    build(21, 8'h45, 8'h01, 8'h08);
    base = rx_q.size();
    send_pkt(21, 2'd0, 1'b1);
    b = 0;
    while (rx_q.size() < base + 7 && b < 300) begin
      @(posedge clk);
      b++;
    end
    #1;
    chk("pre_rst_word7", 64'(out_if.beat.data), 64'(pw[7]));
    chk("pre_rst_passed", 64'(passed), 64'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_if.valid), 64'(0));
    chk("mid_rst_flags", 64'({out_if.beat.sop, out_if.beat.eop,
                              out_if.beat.empty}), 64'(0));
    chk("mid_rst_data", 64'(out_if.beat.data), 64'(0));
    chk("mid_rst_cnt", 64'({passed, dropped}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(in_if.ready), 64'(1));
    build(21, 8'h45, 8'h01, 8'h08);
    base = rx_q.size();
    send_pkt(21, 2'd0, 1'b1);
    expect_pkt(base, 21, 2'd0);
    chk("post_rst_cnt", 64'({passed, dropped}), 64'({16'd1, 16'd0}));
    chk("final_hold", 64'(hold_bad), 64'(0));
    chk("final_in_ready", 64'(rdy_bad), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
